sha1_search: RTL and testbench
==============================

SHA1_SEARCH -- requirements
Module: sha1_search

Interface
REQ-001 SHALL have parameter NONCE_SIZE, default 16: nonce width in bits.
REQ-002 SHALL have parameter NONCE_START, default 503: MSB bit index of the nonce field within the block.
REQ-003 SHALL have parameter ENGINES, default 4: number of parallel hash engines, a power of two, 1..16.
REQ-004 SHALL have parameter STOP_ON_MATCH, default 1: 1 = end the search after the first match round; 0 = report all matches.
REQ-005 SHALL have one clock and one reset: reset is asynchronous and active-low (name the clock and reset ports as the codebase does; the polarity and synchronicity here are fixed) -- ports clk and rst_n.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 start  input  1  one-cycle request; honoured only in IDLE or DONE.
REQ-009 abort  input  1  cancels the running search.
REQ-010 context_in  input  160  initial SHA-1 context; latched on start.
REQ-011 block_in  input  512  template block; nonce bits replaced per engine; latched on start.
REQ-012 target, target_mask  input  160 each  match when (context_out & target_mask) == target; latched on start.
REQ-013 nonce_first, nonce_last  input  NONCE_SIZE each  inclusive search range; latched on start.
REQ-014 busy  output  1  high from the cycle after an accepted start until done.
REQ-015 done  output  1  level; high in DONE state.
REQ-016 found  output  1  level; at least one match reported since the last start.
REQ-017 aborted  output  1  level; the last search ended by abort.
REQ-018 match_valid  output  1  one-cycle strobe per reported match.
REQ-019 match_nonce  output  NONCE_SIZE; match_context  output  160  valid with match_valid; held afterwards.
REQ-020 hash_count  output  32  in-range hashes evaluated since the last start; saturating.

Function
REQ-021 States SHALL be IDLE, RUN, ABORTING, DONE; start in IDLE/DONE -> RUN; start in RUN/ABORTING ignored.
REQ-022 On start, engine i SHALL receive nonce_first+i; each round, all engines SHALL start together and every nonce SHALL advance by ENGINES.
REQ-023 Nonce arithmetic SHALL use NONCE_SIZE+1 bits: an engine whose nonce exceeds nonce_last is out-of-range and its result is discarded; nonce_last = all-ones never wraps to 0.
REQ-024 RUN SHALL go to DONE at the end of the round that contains nonce_last.
REQ-025 If nonce_first > nonce_last, start SHALL go directly to DONE on the next cycle with found=0 and hash_count=0.
REQ-026 A round completes on a single cycle when all engine done pulses occur; that cycle SHALL latch the in-range match vector and the per-match contexts.
REQ-027 Latched matches SHALL be reported one per cycle, lowest engine index (lowest nonce) first, starting the cycle after round completion.
REQ-028 STOP_ON_MATCH=1: a round with any match SHALL be the last round; only the lowest-index match is reported; DONE follows its match_valid by one cycle.
REQ-029 STOP_ON_MATCH=0: reporting SHALL overlap the next round; DONE SHALL be entered only after the final round's matches are all reported.
REQ-030 abort in RUN SHALL enter ABORTING, discard the in-flight round, and then go to DONE with aborted=1; abort in other states is ignored; abort and round completion in the same cycle: abort wins, round discarded.
REQ-031 hash_count SHALL increment by the number of in-range engines at each completed, non-discarded round.
REQ-032 sha1_block done pulses SHALL be ignored in IDLE and DONE.

Reset
REQ-033 On rst_n low: state IDLE; busy, done, found, aborted, match_valid = 0; match_nonce, match_context, hash_count = 0; pending match vector cleared.
REQ-034 Reset mid-search SHALL abandon the search; a later start SHALL restart all engines cleanly (sha1_block restarts on start regardless of prior state).

Structure
REQ-035 Package sha1_pkg SHALL hold the context width (160), the block width (512), and the state enumeration.
REQ-036 SHALL instantiate ENGINES copies of the existing sha1_block (clk, start, context_in, block, done, context_out); no other sub-module.

Verification (NONCE_SIZE=4, NONCE_START=503, ENGINES=4)
REQ-037 first=0, last=15, no match -> 4 rounds, done with found=0, hash_count=16.
REQ-038 first=0, last=15, mask selects the hashes of nonces 6 and 5 (same round), STOP_ON_MATCH=1 -> one match_valid with nonce 5, then done, hash_count=8.
REQ-039 Same stimulus as REQ-038 with STOP_ON_MATCH=0 -> match_valid for 5 and then 6 on consecutive cycles; done after nonce 15 with hash_count=16.
REQ-040 first=13, last=15 -> one round; engine 3 (nonce 16) discarded; hash_count=3; a match on nonce 0 is never reported.
REQ-041 first=9, last=3 -> done on the cycle after start, found=0; abort in mid-RUN -> done, aborted=1, no match_valid.
REQ-042 rst_n pulsed low mid-round, then start -> all outputs reset; the new search completes correctly with no stale match_valid.

Source files
------------

// File: rtl/sha1_pkg.sv
// Shared widths, the search controller state encoding and the SHA-1 rotate helper.
package sha1_pkg;

  localparam int CTX_W = 160;
  localparam int BLK_W = 512;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ABORTING,
    DONE
  } state_t;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/sha1_block.sv
// One SHA-1 compression engine, one round per clock; start reloads it whatever it was doing.
// context_out is the fed-forward context; done pulses for one cycle when it updates.
module sha1_block
  import sha1_pkg::*;
(
  input  logic             clk,
  input  logic             start,
  input  logic [CTX_W-1:0] context_in,
  input  logic [BLK_W-1:0] block,
  output logic             done,
  output logic [CTX_W-1:0] context_out
);

  logic [31:0]       a, b, c, d, e;
  logic [15:0][31:0] w;
  logic [CTX_W-1:0]  ctx_q;
  logic [6:0]        t;
  logic              running;
  logic [31:0]       f, k, temp, w_new;

  always_comb begin
    if (t < 7'd20) begin
      f = (b & c) | (~b & d);
      k = 32'h5A827999;
    end else if (t < 7'd40) begin
      f = b ^ c ^ d;
      k = 32'h6ED9EBA1;
    end else if (t < 7'd60) begin
      f = (b & c) | (b & d) | (c & d);
      k = 32'h8F1BBCDC;
    end else begin
      f = b ^ c ^ d;
      k = 32'hCA62C1D6;
    end
    temp  = rotl(a, 5) + f + e + k + w[0];
    // w holds W[t..t+15]; the next schedule word is derived from that window
    w_new = rotl(w[13] ^ w[8] ^ w[2] ^ w[0], 1);
  end

  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (start) begin
      ctx_q   <= context_in;
      a       <= context_in[159:128];
      b       <= context_in[127:96];
      c       <= context_in[95:64];
      d       <= context_in[63:32];
      e       <= context_in[31:0];
      for (int i = 0; i < 16; i++) w[i] <= block[BLK_W-1-32*i -: 32];
      t       <= '0;
      running <= 1'b1;
    end else if (running) begin
      a <= temp;
      b <= a;
      c <= rotl(b, 30);
      d <= c;
      e <= d;
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= w_new;
      t     <= t + 7'd1;
      if (t == 7'd79) begin
        running     <= 1'b0;
        done        <= 1'b1;
        context_out <= {ctx_q[159:128] + temp, ctx_q[127:96] + a,
                        ctx_q[95:64] + rotl(b, 30), ctx_q[63:32] + c,
                        ctx_q[31:0] + d};
      end
    end
  end

endmodule

// File: rtl/sha1_search.sv
// Nonce search: ENGINES parallel SHA-1 engines sweep a nonce range in lock-step rounds and
// report masked-target matches one per cycle, lowest nonce first.
module sha1_search
  import sha1_pkg::*;
#(
  parameter int NONCE_SIZE    = 16,
  parameter int NONCE_START   = 503,
  parameter int ENGINES       = 4,
  parameter int STOP_ON_MATCH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CTX_W-1:0]      context_in,
  input  logic [BLK_W-1:0]      block_in,
  input  logic [CTX_W-1:0]      target,
  input  logic [CTX_W-1:0]      target_mask,
  input  logic [NONCE_SIZE-1:0] nonce_first,
  input  logic [NONCE_SIZE-1:0] nonce_last,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic                  aborted,
  output logic                  match_valid,
  output logic [NONCE_SIZE-1:0] match_nonce,
  output logic [CTX_W-1:0]      match_context,
  output logic [31:0]           hash_count
);

  localparam int NW   = NONCE_SIZE + 1;
  localparam int IDXW = (ENGINES > 1) ? $clog2(ENGINES) : 1;

  state_t                          state;
  logic [CTX_W-1:0]                ctx_q, target_q, mask_q;
  logic [BLK_W-1:0]                blk_q;
  logic [NW-1:0]                   cur, last_q;
  logic [NONCE_SIZE-1:0]           pend_base, rep_nonce;
  logic                            eng_start, round_active, round_done, last_round;
  logic [ENGINES-1:0]              pend, pend_clr, eng_done, in_range, is_match, hit, hit_sel;
  logic [ENGINES-1:0][CTX_W-1:0]   eng_ctx, ctx_lat;
  logic [IDXW-1:0]                 rep_idx;
  logic [5:0]                      n_in;
  logic [32:0]                     count_sum;

  for (genvar g = 0; g < ENGINES; g++) begin : g_eng
    logic [NW-1:0]    nonce;
    logic [BLK_W-1:0] blk;

    assign nonce       = cur + NW'(g);
    assign in_range[g] = (nonce <= last_q);
    assign is_match[g] = ((eng_ctx[g] & mask_q) == target_q);

    always_comb begin
      blk = blk_q;
      blk[NONCE_START -: NONCE_SIZE] = nonce[NONCE_SIZE-1:0];
    end

    sha1_block u_engine (
      .clk        (clk),
      .start      (eng_start),
      .context_in (ctx_q),
      .block      (blk),
      .done       (eng_done[g]),
      .context_out(eng_ctx[g])
    );
  end

  always_comb begin
    hit        = in_range & is_match;
    hit_sel    = (STOP_ON_MATCH != 0) ? (hit & (~hit + ENGINES'(1))) : hit;
    round_done = round_active && (&eng_done);
    last_round = (cur + NW'(ENGINES - 1)) >= last_q;
    n_in = '0;
    for (int i = 0; i < ENGINES; i++) n_in = n_in + 6'(in_range[i]);
    count_sum = {1'b0, hash_count} + 33'(n_in);
    rep_idx = '0;
    for (int i = ENGINES - 1; i >= 0; i--) if (pend[i]) rep_idx = IDXW'(i);
    pend_clr = pend;
    pend_clr[rep_idx] = 1'b0;
    rep_nonce = pend_base + NONCE_SIZE'(rep_idx);
  end

  // A round takes 80+ cycles, so pending reports always drain before the next round lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      found         <= 1'b0;
      aborted       <= 1'b0;
      match_valid   <= 1'b0;
      match_nonce   <= '0;
      match_context <= '0;
      hash_count    <= '0;
      pend          <= '0;
      pend_base     <= '0;
      ctx_lat       <= '0;
      ctx_q         <= '0;
      blk_q         <= '0;
      target_q      <= '0;
      mask_q        <= '0;
      cur           <= '0;
      last_q        <= '0;
      eng_start     <= 1'b0;
      round_active  <= 1'b0;
    end else begin
      eng_start   <= 1'b0;
      match_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            ctx_q      <= context_in;
            blk_q      <= block_in;
            target_q   <= target;
            mask_q     <= target_mask;
            cur        <= {1'b0, nonce_first};
            last_q     <= {1'b0, nonce_last};
            found      <= 1'b0;
            aborted    <= 1'b0;
            hash_count <= '0;
            pend       <= '0;
            if (nonce_first > nonce_last) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state        <= RUN;
              done         <= 1'b0;
              busy         <= 1'b1;
              eng_start    <= 1'b1;
              round_active <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state        <= ABORTING;
            pend         <= '0;
            round_active <= 1'b0;
          end else begin
            if (|pend) begin
              match_valid   <= 1'b1;
              match_nonce   <= rep_nonce;
              match_context <= ctx_lat[rep_idx];
              found         <= 1'b1;
            end
            if (round_done) begin
              pend       <= hit_sel;
              pend_base  <= cur[NONCE_SIZE-1:0];
              ctx_lat    <= eng_ctx;
              hash_count <= count_sum[32] ? '1 : count_sum[31:0];
              if (last_round || ((STOP_ON_MATCH != 0) && (|hit))) begin
                round_active <= 1'b0;
                if (hit_sel == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                end
              end else begin
                cur       <= cur + NW'(ENGINES);
                eng_start <= 1'b1;
              end
            end else begin
              pend <= pend_clr;
              if (!round_active && (pend == '0)) begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end
            end
          end
        end
        ABORTING: begin
          state   <= DONE;
          done    <= 1'b1;
          busy    <= 1'b0;
          aborted <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_search.sv
// Scoreboard bench: two searchers (stop-on-match and report-all) share stimulus; a SHA-1
// reference function supplies expected contexts and monitors pop per-DUT expectation queues.
module tb_sha1_search;

  localparam logic [511:0] TMPL = {32'h61626380, 32'h13579bdf, 32'h2468ace0, 32'hdeadbeef,
                                   32'h0badf00d, 32'hcafebabe, 32'h01234567, 32'h89abcdef,
                                   32'hfedcba98, 32'h76543210, 32'h0f1e2d3c, 32'h4b5a6978,
                                   32'h8796a5b4, 32'hc3d2e1f0, 32'h00000000, 32'h00000018};
  localparam logic [159:0] IV = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE,
                                 32'h10325476, 32'hC3D2E1F0};

  typedef struct packed {
    logic [3:0]   nonce;
    logic [159:0] ctx;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n, start, abort;
  logic [159:0] context_in, target, target_mask;
  logic [511:0] block_in;
  logic [3:0]   nonce_first, nonce_last;

  logic         busy0, done0, found0, aborted0, match_valid0;
  logic [3:0]   match_nonce0;
  logic [159:0] match_context0;
  logic [31:0]  hash_count0;
  logic         busy1, done1, found1, aborted1, match_valid1;
  logic [3:0]   match_nonce1;
  logic [159:0] match_context1;
  logic [31:0]  hash_count1;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t exp0[$], exp1[$];
  int   mv_cycles0[$], mv_cycles1[$];
  int   done_rise0 = 0;
  logic prev_done0 = 1'b0;
  exp_t e0, e1;
  logic [159:0] h0, h2, h3, h5, h6, mask;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sha1_search #(.NONCE_SIZE(4), .NONCE_START(503), .ENGINES(4), .STOP_ON_MATCH(1)) dut_stop (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .context_in(context_in),
    .block_in(block_in), .target(target), .target_mask(target_mask),
    .nonce_first(nonce_first), .nonce_last(nonce_last), .busy(busy0), .done(done0),
    .found(found0), .aborted(aborted0), .match_valid(match_valid0),
    .match_nonce(match_nonce0), .match_context(match_context0), .hash_count(hash_count0));

  sha1_search #(.NONCE_SIZE(4), .NONCE_START(503), .ENGINES(4), .STOP_ON_MATCH(0)) dut_all (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .context_in(context_in),
    .block_in(block_in), .target(target), .target_mask(target_mask),
    .nonce_first(nonce_first), .nonce_last(nonce_last), .busy(busy1), .done(done1),
    .found(found1), .aborted(aborted1), .match_valid(match_valid1),
    .match_nonce(match_nonce1), .match_context(match_context1), .hash_count(hash_count1));

  function automatic logic [159:0] sha1_model(input logic [159:0] ctx, input logic [511:0] blk);
    logic [31:0] w[80];
    logic [31:0] a, b, c, d, e, f, k, tmp;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 80; t++) begin
      tmp  = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
      w[t] = {tmp[30:0], tmp[31]};
    end
    a = ctx[159:128]; b = ctx[127:96]; c = ctx[95:64]; d = ctx[63:32]; e = ctx[31:0];
    for (int t = 0; t < 80; t++) begin
      if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (t < 40) begin f = b ^ c ^ d;                    k = 32'h6ED9EBA1; end
      else if (t < 60) begin f = (b & c) | (b & d) | (c & d);  k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                    k = 32'hCA62C1D6; end
      tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
    end
    return {ctx[159:128] + a, ctx[127:96] + b, ctx[95:64] + c, ctx[63:32] + d, ctx[31:0] + e};
  endfunction

  function automatic logic [511:0] make_block(input logic [3:0] n);
    logic [511:0] blk;
    blk = TMPL;
    blk[503:500] = n;
    return blk;
  endfunction

  task automatic checkOutput(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic checkContext(input string name, input logic [159:0] act, input logic [159:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] f, input logic [3:0] l,
                               input logic [159:0] tg, input logic [159:0] mk);
    @(negedge clk);
    nonce_first = f;
    nonce_last  = l;
    target      = tg;
    target_mask = mk;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    int n = 0;
    while (!(done0 && done1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, int'(done0 && done1), 1);
  endtask

  // Stop-on-match searcher monitor
  always @(negedge clk) begin
    if (match_valid0) begin
      mv_cycles0.push_back(cyc);
      if (exp0.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL stop_unexpected_match: got nonce %0d, want no report", match_nonce0);
      end else begin
        e0 = exp0.pop_front();
        checkOutput("stop_match_nonce", int'(match_nonce0), int'(e0.nonce));
        checkContext("stop_match_context", match_context0, e0.ctx);
      end
    end
    if (done0 && !prev_done0) done_rise0 = cyc;
    prev_done0 = done0;
  end

  // Report-all searcher monitor
  always @(negedge clk) begin
    if (match_valid1) begin
      mv_cycles1.push_back(cyc);
      if (exp1.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL all_unexpected_match: got nonce %0d, want no report", match_nonce1);
      end else begin
        e1 = exp1.pop_front();
        checkOutput("all_match_nonce", int'(match_nonce1), int'(e1.nonce));
        checkContext("all_match_context", match_context1, e1.ctx);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    context_in = IV; block_in = TMPL;
    target = '0; target_mask = '0; nonce_first = '0; nonce_last = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_busy", int'({busy0, busy1}), 0);
    checkOutput("reset_done", int'({done0, done1}), 0);
    checkOutput("reset_flags", int'({found0, aborted0, found1, aborted1}), 0);
    checkOutput("reset_count", int'(hash_count0 | hash_count1), 0);

    $display("[TB] full range, no match");
    applyStimulus(4'd0, 4'd15, '0, '1);
    checkOutput("run_busy", int'({busy0, busy1}), 3);
    waitDone("nomatch_done", 600);
    checkOutput("nomatch_found", int'({found0, found1}), 0);
    checkOutput("nomatch_count_stop", int'(hash_count0), 16);
    checkOutput("nomatch_count_all", int'(hash_count1), 16);
    checkOutput("nomatch_aborted", int'({aborted0, aborted1}), 0);

    $display("[TB] nonces 5 and 6 match in the same round");
    h5 = sha1_model(IV, make_block(4'd5));
    h6 = sha1_model(IV, make_block(4'd6));
    mask = ~(h5 ^ h6);
    exp0.push_back('{4'd5, h5});
    exp1.push_back('{4'd5, h5});
    exp1.push_back('{4'd6, h6});
    mv_cycles0.delete();
    mv_cycles1.delete();
    applyStimulus(4'd0, 4'd15, h5 & mask, mask);
    waitDone("match_done", 600);
    checkOutput("match_found", int'({found0, found1}), 3);
    checkOutput("match_count_stop", int'(hash_count0), 8);
    checkOutput("match_count_all", int'(hash_count1), 16);
    checkOutput("match_pending_stop", exp0.size(), 0);
    checkOutput("match_pending_all", exp1.size(), 0);
    checkOutput("stop_report_count", mv_cycles0.size(), 1);
    if (mv_cycles0.size() == 1)
      checkOutput("stop_done_lag", done_rise0 - mv_cycles0[0], 1);
    checkOutput("all_report_count", mv_cycles1.size(), 2);
    if (mv_cycles1.size() == 2)
      checkOutput("all_report_spacing", mv_cycles1[1] - mv_cycles1[0], 1);

    $display("[TB] empty range");
    applyStimulus(4'd9, 4'd3, '0, '0);
    checkOutput("empty_done_next", int'({done0, done1}), 3);
    checkOutput("empty_busy", int'({busy0, busy1}), 0);
    checkOutput("empty_found", int'({found0, found1}), 0);
    checkOutput("empty_count", int'(hash_count0 | hash_count1), 0);

    $display("[TB] partial round, wrapped engine hits");
    h0 = sha1_model(IV, make_block(4'd0));
    applyStimulus(4'd13, 4'd15, h0, '1);
    waitDone("partial_done", 300);
    checkOutput("partial_count_stop", int'(hash_count0), 3);
    checkOutput("partial_count_all", int'(hash_count1), 3);
    checkOutput("partial_found", int'({found0, found1}), 0);

    $display("[TB] abort mid-run");
    applyStimulus(4'd0, 4'd15, '0, '0);
    repeat (30) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    waitDone("abort_done", 5);
    checkOutput("abort_flag", int'({aborted0, aborted1}), 3);
    checkOutput("abort_found", int'({found0, found1}), 0);
    checkOutput("abort_count", int'(hash_count0 | hash_count1), 0);
    repeat (120) @(negedge clk);
    checkOutput("abort_still_done", int'({done0, done1, found0, found1}), 12);

    $display("[TB] reset mid-round then restart");
    applyStimulus(4'd0, 4'd15, '0, '0);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_status", int'({busy0, done0, found0, aborted0, match_valid0,
                                         busy1, done1, found1, aborted1, match_valid1}), 0);
    checkOutput("midreset_nonce", int'({match_nonce0, match_nonce1}), 0);
    checkOutput("midreset_count", int'(hash_count0 | hash_count1), 0);
    checkContext("midreset_context", match_context0 | match_context1, '0);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    checkOutput("idle_ignores_engines", int'({busy0, done0, busy1, done1}), 0);
    h2 = sha1_model(IV, make_block(4'd2));
    h3 = sha1_model(IV, make_block(4'd3));
    exp0.push_back('{4'd2, h2});
    exp1.push_back('{4'd2, h2});
    exp1.push_back('{4'd3, h3});
    applyStimulus(4'd2, 4'd3, '0, '0);
    waitDone("restart_done", 300);
    checkOutput("restart_count", int'(hash_count0 + hash_count1), 4);
    checkOutput("restart_found", int'({found0, found1}), 3);
    checkOutput("restart_pending", exp0.size() + exp1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
